// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared pipeline-control types and default sizes
package rice_core_pkg;
  localparam int RC_XLEN = 32;
  localparam int RC_STAGES = 5;
  typedef logic [RC_STAGES-1:0] rice_core_stage_mask;
  typedef struct packed {
    rice_core_stage_mask valid;
    logic flush;
    logic [RC_XLEN-1:0] flush_pc;
  } rice_core_pipeline_ctrl_state;
endpackage

// File: rtl/rice_core_flush_arbiter.sv
// rice_core_flush_arbiter: oldest-first pick among flush requests with kill mask of younger stages
module rice_core_flush_arbiter #(
  parameter int STAGES = 5,
  parameter int XLEN = 32,
  parameter int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic [STAGES-1:0]      req,
  input  logic [STAGES*XLEN-1:0] pcs,
  output logic [STAGES-1:0]      win,
  output logic [IDX_W-1:0]       idx,
  output logic [XLEN-1:0]        pc,
  output logic [STAGES-1:0]      kill
);
  // later iterations overwrite earlier ones, so the highest (oldest) request wins; win-1 marks every younger stage
  always_comb begin
    win = '0;
    idx = '0;
    pc = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (req[k]) begin
        win = '0;
        win[k] = 1'b1;
        idx = k[IDX_W-1:0];
        pc = pcs[k*XLEN +: XLEN];
      end
    end
    kill = (|req) ? win - STAGES'(1) : '0;
  end
endmodule

// File: rtl/rice_core_pipeline_ctrl.sv
// rice_core_pipeline_ctrl: per-stage valid/enable, bubble and flush control with saturating perf counters
module rice_core_pipeline_ctrl
  import rice_core_pkg::*;
#(
  parameter int XLEN = RC_XLEN,
  parameter int STAGES = RC_STAGES,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fetch_valid,
  input  logic [STAGES-1:0]      i_stall_req,
  input  logic [STAGES-1:0]      i_flush_req,
  input  logic [STAGES*XLEN-1:0] i_flush_pc,
  output logic [STAGES-1:0]      o_valid,
  output logic [STAGES-1:0]      o_enable,
  output logic                   o_flush,
  output logic [XLEN-1:0]        o_flush_pc,
  output logic                   o_retire,
  output logic [CNT_W-1:0]       o_retire_cnt,
  output logic [CNT_W-1:0]       o_stall_cnt,
  output logic [CNT_W-1:0]       o_flush_cnt
);
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  rice_core_pipeline_ctrl_state st;
  logic [STAGES-1:0] stall, flush, hold, kill, win, nv;
  logic [IDX_W-1:0] win_idx;
  logic [XLEN-1:0] win_pc;
  assign stall = i_stall_req & st.valid;
  assign flush = i_flush_req & st.valid;
  assign hold[STAGES-1] = stall[STAGES-1];
  genvar i;
  generate
    for (i = 0; i < STAGES-1; i++) begin : g_hold
      assign hold[i] = stall[i] | hold[i+1];
    end
  endgenerate
  assign o_enable = ~hold;
  assign o_valid = st.valid;
  assign o_flush = st.flush;
  assign o_flush_pc = st.flush_pc;
  assign o_retire = st.valid[STAGES-1] & ~stall[STAGES-1];
  rice_core_flush_arbiter #(.STAGES(STAGES), .XLEN(XLEN), .IDX_W(IDX_W)) u_arb (
    .req(flush),
    .pcs(i_flush_pc),
    .win(win),
    .idx(win_idx),
    .pc(win_pc),
    .kill(kill)
  );
  // the reported index must always point at the one-hot winner
  always_comb assert (!(|win) || win[win_idx]);
  // next valid: kill beats hold, hold keeps, stage 0 takes fetch, a held predecessor leaves a bubble
  always_comb begin
    nv[0] = kill[0] ? 1'b0 : hold[0] ? st.valid[0] : i_fetch_valid;
    for (int k = 1; k < STAGES; k++)
      nv[k] = kill[k] ? 1'b0 : hold[k] ? st.valid[k] : hold[k-1] ? 1'b0 : st.valid[k-1];
  end
  // all state: valid bits, registered redirect, saturating counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st.valid <= '0;
      st.flush <= 1'b1;
      st.flush_pc <= RESET_PC;
      o_retire_cnt <= '0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      st.valid <= nv;
      st.flush <= |flush;
      st.flush_pc <= (|flush) ? win_pc : st.flush_pc;
      o_retire_cnt <= (o_retire && ~&o_retire_cnt) ? o_retire_cnt + CNT_W'(1) : o_retire_cnt;
      o_stall_cnt <= ((|stall) && ~&o_stall_cnt) ? o_stall_cnt + CNT_W'(1) : o_stall_cnt;
      o_flush_cnt <= ((|flush) && ~&o_flush_cnt) ? o_flush_cnt + CNT_W'(1) : o_flush_cnt;
    end
  end
endmodule

// File: tb/tb_rice_core_pipeline_ctrl.sv
// tb_rice_core_pipeline_ctrl: scoreboard bench against an index-based pipeline model
module tb_rice_core_pipeline_ctrl;
  localparam int S = 5;
  localparam int X = 32;
  localparam int W = 4;
  localparam int CMAX = 15;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fv = 1'b0;
  logic [S-1:0] sr = '0, fr = '0;
  logic [S*X-1:0] fpc = '0;
  logic [S-1:0] o_valid, o_enable;
  logic o_flush, o_retire;
  logic [X-1:0] o_flush_pc;
  logic [W-1:0] o_retire_cnt, o_stall_cnt, o_flush_cnt;
  rice_core_pipeline_ctrl #(.XLEN(X), .STAGES(S), .RESET_PC(RPC), .CNT_W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_fetch_valid(fv), .i_stall_req(sr), .i_flush_req(fr),
    .i_flush_pc(fpc), .o_valid(o_valid), .o_enable(o_enable), .o_flush(o_flush),
    .o_flush_pc(o_flush_pc), .o_retire(o_retire), .o_retire_cnt(o_retire_cnt),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit chk_comb;
    logic [S-1:0] en;
    logic ret;
    logic [S-1:0] v;
    logic fl;
    logic [31:0] pc;
    int rc, sc, fc;
  } exp_t;
  exp_t q[$];
  logic [S-1:0] mv = '0;
  logic mfl = 1'b1;
  logic [31:0] mpc = RPC;
  int mrc = 0, msc = 0, mfc = 0;
  bit known = 0;
  int pass_n = 0, tot_n = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tot_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s got %0h want %0h", n, a, e);
  endtask
  function automatic int sat(input int c, input bit ev);
    return (ev && c < CMAX) ? c + 1 : c;
  endfunction
  task automatic cyc(input bit r, input bit f, input logic [S-1:0] s, input logic [S-1:0] fl, input logic [S*X-1:0] p);
    exp_t e;
    int os, w;
    logic [S-1:0] sq, fq, nv;
    @(negedge clk);
    rst = r; fv = f; sr = s; fr = fl; fpc = p;
    sq = s & mv;
    fq = fl & mv;
    os = -1;
    w = -1;
    for (int k = 0; k < S; k++) begin
      if (sq[k]) os = k;
      if (fq[k]) w = k;
    end
    e.chk_comb = known;
    for (int k = 0; k < S; k++) e.en[k] = (k > os);
    e.ret = mv[S-1] & ~sq[S-1];
    for (int k = 0; k < S; k++)
      nv[k] = (k < w) ? 1'b0 : (k <= os) ? mv[k] : (k == 0) ? f : (k - 1 <= os) ? 1'b0 : mv[k-1];
    if (r) begin
      mv = '0; mfl = 1'b1; mpc = RPC; mrc = 0; msc = 0; mfc = 0;
    end else begin
      mrc = sat(mrc, e.ret);
      msc = sat(msc, os >= 0);
      mfc = sat(mfc, w >= 0);
      mfl = (w >= 0);
      if (w >= 0) mpc = p[w*X +: X];
      mv = nv;
    end
    known = 1;
    e.v = mv; e.fl = mfl; e.pc = mpc; e.rc = mrc; e.sc = msc; e.fc = mfc;
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 1, '0, '0, '0);
  endtask
  // monitor: combinational outputs mid-cycle, registered outputs just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_comb) begin
          chk("enable", o_enable, e.en);
          chk("retire", o_retire, e.ret);
        end
        @(posedge clk);
        #1;
        chk("valid", o_valid, e.v);
        chk("flush", o_flush, e.fl);
        chk("flush_pc", o_flush_pc, e.pc);
        chk("retire_cnt", o_retire_cnt, e.rc);
        chk("stall_cnt", o_stall_cnt, e.sc);
        chk("flush_cnt", o_flush_cnt, e.fc);
      end
    end
  end
  initial begin
    logic [S*X-1:0] p;
    int n;
    repeat (2) @(posedge clk);
    repeat (2) cyc(1, 1, '0, '0, '0);
    idle(7);
    repeat (3) cyc(0, 1, 5'b00100, '0, '0);
    idle(3);
    p = '0; p[2*X +: X] = 32'h100;
    cyc(0, 1, '0, 5'b00100, p);
    idle(5);
    p = '0; p[1*X +: X] = 32'h200; p[3*X +: X] = 32'h300;
    cyc(0, 1, '0, 5'b01010, p);
    idle(5);
    p = '0; p[3*X +: X] = 32'h340; p[4*X +: X] = 32'h440;
    cyc(0, 1, '0, 5'b01000, p);
    cyc(0, 1, '0, 5'b10000, p);
    idle(5);
    p = '0; p[1*X +: X] = 32'h500;
    cyc(0, 1, 5'b01000, 5'b00010, p);
    idle(5);
    cyc(0, 1, 5'b00100, 5'b00100, p);
    idle(5);
    cyc(1, 0, '0, '0, '0);
    for (int k = 0; k < S; k++) p[k*X +: X] = $urandom;
    repeat (4) cyc(0, 0, 5'b11111, 5'b11111, p);
    repeat (25) cyc(0, 1, 5'($urandom & $urandom), '0, '0);
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < S; k++) p[k*X +: X] = $urandom;
      cyc(0, 1, '0, 5'($urandom & $urandom & $urandom), p);
    end
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < S; k++) p[k*X +: X] = $urandom;
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 5'($urandom & $urandom & $urandom),
          5'($urandom & $urandom & $urandom & $urandom), p);
    end
    idle(6);
    p = '0; p[4*X +: X] = 32'h0bad_0000;
    cyc(0, 1, '0, 5'b10000, p);
    cyc(1, 1, '0, 5'b10000, p);
    idle(3);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    if (q.size() > 0) begin
      tot_n++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
